// File: rtl/tone_detector.sv
// Tone detector: measures the period between rising edges of an asynchronous tone line,
// classifies it as 1 kHz or 512 Hz, and reports lock/unlock events and completed tones.
module tone_detector #(
  parameter int CNT_W       = 18,
  parameter int P1K_MIN     = 98000,
  parameter int P1K_MAX     = 102000,
  parameter int P512_MIN    = 191406,
  parameter int P512_MAX    = 199219,
  parameter int MIN_PERIODS = 4,
  parameter int TIMEOUT     = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beep_in,
  output logic             tone_valid,
  output logic             tone_is_1k,
  output logic             tone_is_512,
  output logic             tone_start,
  output logic             tone_end,
  output logic [CNT_W-1:0] period_out,
  output logic [7:0]       tone_cnt
);

  localparam int MW = $clog2(MIN_PERIODS + 1);
  localparam logic [CNT_W-1:0] P1K_MIN_C  = CNT_W'(P1K_MIN);
  localparam logic [CNT_W-1:0] P1K_MAX_C  = CNT_W'(P1K_MAX);
  localparam logic [CNT_W-1:0] P512_MIN_C = CNT_W'(P512_MIN);
  localparam logic [CNT_W-1:0] P512_MAX_C = CNT_W'(P512_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]    MATCH_LOCK = MW'(MIN_PERIODS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEASURE = 2'd1, ST_LOCKED = 2'd2} state_t;
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_1K = 2'd1, CLS_512 = 2'd2} cls_t;

  function automatic cls_t classify(input logic [CNT_W-1:0] p);
    cls_t c;
    if (p >= P1K_MIN_C && p <= P1K_MAX_C) begin
      c = CLS_1K;
    end else if (p >= P512_MIN_C && p <= P512_MAX_C) begin
      c = CLS_512;
    end else begin
      c = CLS_NONE;
    end
    return c;
  endfunction

  state_t           state_r, state_s;
  cls_t             cand_r, cand_s, cls_s, seed_cand_s;
  logic [MW-1:0]    match_cnt_r, match_cnt_s, seed_match_s;
  logic [CNT_W-1:0] per_cnt_r, per_cnt_s, p_s;
  logic             sync0_r, sync1_r, prev_r, rise_s, tout_s;
  logic             valid_r, valid_s, is_1k_r, is_1k_s, is_512_r, is_512_s;
  logic             start_r, start_s, end_r, end_s;
  logic [CNT_W-1:0] period_r, period_s;
  logic [7:0]       tone_cnt_r, tone_cnt_s;

  assign rise_s = sync1_r & ~prev_r;
  assign p_s    = per_cnt_r + CNT_ONE;
  assign cls_s  = classify(p_s);
  assign tout_s = (per_cnt_r == TIMEOUT_C) & ~rise_s;

  // Candidate/match tracking for a freshly measured period (shared by MEASURE and LOCKED exit).
  always_comb begin
    seed_cand_s  = CLS_NONE;
    seed_match_s = '0;
    if (cls_s == CLS_NONE) begin
      seed_cand_s  = CLS_NONE;
      seed_match_s = '0;
    end else if (cls_s == cand_r) begin
      seed_cand_s  = cand_r;
      seed_match_s = match_cnt_r + MATCH_ONE;
    end else begin
      seed_cand_s  = cls_s;
      seed_match_s = MATCH_ONE;
    end
  end

  // Next-state and next-output logic for the period counter and lock FSM.
  always_comb begin
    state_s     = state_r;
    cand_s      = cand_r;
    match_cnt_s = match_cnt_r;
    valid_s     = valid_r;
    is_1k_s     = is_1k_r;
    is_512_s    = is_512_r;
    start_s     = 1'b0;
    end_s       = 1'b0;
    period_s    = period_r;
    tone_cnt_s  = tone_cnt_r;

    if (rise_s) begin
      per_cnt_s = '0;
    end else if (per_cnt_r != CNT_SAT) begin
      per_cnt_s = per_cnt_r + CNT_ONE;
    end else begin
      per_cnt_s = per_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s     = ST_MEASURE;
          cand_s      = CLS_NONE;
          match_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          cand_s      = seed_cand_s;
          match_cnt_s = seed_match_s;
          if (seed_match_s == MATCH_LOCK) begin
            state_s  = ST_LOCKED;
            start_s  = 1'b1;
            valid_s  = 1'b1;
            is_1k_s  = (seed_cand_s == CLS_1K);
            is_512_s = (seed_cand_s == CLS_512);
            period_s = p_s;
          end else begin
            state_s = ST_MEASURE;
          end
        end else if (tout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (rise_s && cls_s == cand_r) begin
          period_s = p_s;
        end else if (rise_s || tout_s) begin
          // A rise of the wrong class re-seeds the search; silence drops straight to IDLE.
          state_s     = rise_s ? ST_MEASURE : ST_IDLE;
          cand_s      = rise_s ? seed_cand_s : CLS_NONE;
          match_cnt_s = rise_s ? seed_match_s : '0;
          end_s       = 1'b1;
          valid_s     = 1'b0;
          is_1k_s     = 1'b0;
          is_512_s    = 1'b0;
          tone_cnt_s  = tone_cnt_r + 8'd1;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cand_s      = CLS_NONE;
        match_cnt_s = '0;
      end
    endcase
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_r     <= 1'b0;
      sync1_r     <= 1'b0;
      prev_r      <= 1'b0;
      state_r     <= ST_IDLE;
      cand_r      <= CLS_NONE;
      match_cnt_r <= '0;
      per_cnt_r   <= '0;
      valid_r     <= 1'b0;
      is_1k_r     <= 1'b0;
      is_512_r    <= 1'b0;
      start_r     <= 1'b0;
      end_r       <= 1'b0;
      period_r    <= '0;
      tone_cnt_r  <= 8'd0;
    end else begin
      sync0_r     <= beep_in;
      sync1_r     <= sync0_r;
      prev_r      <= sync1_r;
      state_r     <= state_s;
      cand_r      <= cand_s;
      match_cnt_r <= match_cnt_s;
      per_cnt_r   <= per_cnt_s;
      valid_r     <= valid_s;
      is_1k_r     <= is_1k_s;
      is_512_r    <= is_512_s;
      start_r     <= start_s;
      end_r       <= end_s;
      period_r    <= period_s;
      tone_cnt_r  <= tone_cnt_s;
    end
  end

  assign tone_valid  = valid_r;
  assign tone_is_1k  = is_1k_r;
  assign tone_is_512 = is_512_r;
  assign tone_start  = start_r;
  assign tone_end    = end_r;
  assign period_out  = period_r;
  assign tone_cnt    = tone_cnt_r;

endmodule
